// File: rtl/uart_tx_unit.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Line encodings for ParityType and BaudRate match the companion receiver.
module uart_tx_unit #(
    parameter int unsigned CLOCK_FREQ = 50_000_000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Send,
    input  logic [7:0] DataIn,
    input  logic [1:0] ParityType,
    input  logic [1:0] BaudRate,
    output logic       DataTx,
    output logic       Busy,
    output logic       Done
);

    localparam int unsigned N0    = (CLOCK_FREQ + 1200) / 2400;
    localparam int unsigned N1    = (CLOCK_FREQ + 2400) / 4800;
    localparam int unsigned N2    = (CLOCK_FREQ + 4800) / 9600;
    localparam int unsigned N3    = (CLOCK_FREQ + 9600) / 19200;
    localparam int unsigned DIV_W = (N0 > 1) ? $clog2(N0) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_next;
    logic [DIV_W-1:0] div_cnt, div_next, div_last;
    logic [2:0]       idx, idx_next, idx_inc;
    logic [7:0]       sh_data, sh_data_next;
    logic [1:0]       sh_par, sh_par_next;
    logic [1:0]       sh_baud, sh_baud_next;
    logic             tx_next, busy_next, done_next;
    logic             bit_end, par_en, par_bit;

    always_comb begin
        case (sh_baud)
            2'b00:   div_last = DIV_W'(N0 - 1);
            2'b01:   div_last = DIV_W'(N1 - 1);
            2'b10:   div_last = DIV_W'(N2 - 1);
            default: div_last = DIV_W'(N3 - 1);
        endcase
    end

    assign bit_end = (div_cnt == div_last);
    assign par_en  = (sh_par == 2'b01) || (sh_par == 2'b10);
    assign par_bit = (sh_par == 2'b10) ? ^sh_data : ~^sh_data;
    assign idx_inc = idx + 3'd1;

    // Next-cycle line value is computed here so DataTx itself is a plain flop.
    always_comb begin
        state_next   = state;
        div_next     = bit_end ? '0 : div_cnt + 1'b1;
        idx_next     = idx;
        sh_data_next = sh_data;
        sh_par_next  = sh_par;
        sh_baud_next = sh_baud;
        tx_next      = DataTx;
        busy_next    = Busy;
        done_next    = 1'b0;
        case (state)
            IDLE: begin
                div_next = '0;
                idx_next = '0;
                tx_next  = 1'b1;
                if (Send) begin
                    sh_data_next = DataIn;
                    sh_par_next  = ParityType;
                    sh_baud_next = BaudRate;
                    state_next   = START;
                    tx_next      = 1'b0;
                    busy_next    = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    idx_next   = '0;
                    tx_next    = sh_data[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == 3'd7) begin
                        state_next = par_en ? PARITY : STOP;
                        tx_next    = par_en ? par_bit : 1'b1;
                    end else begin
                        idx_next = idx_inc;
                        tx_next  = sh_data[idx_inc];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            idx     <= '0;
            sh_data <= '0;
            sh_par  <= '0;
            sh_baud <= '0;
            DataTx  <= 1'b1;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state   <= state_next;
            div_cnt <= div_next;
            idx     <= idx_next;
            sh_data <= sh_data_next;
            sh_par  <= sh_par_next;
            sh_baud <= sh_baud_next;
            DataTx  <= tx_next;
            Busy    <= busy_next;
            Done    <= done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Self-checking bench for uart_tx_unit: a bit-list frame model checked cycle by cycle,
// plus a mid-bit decoder that rebuilds the byte from the line.
module tb_uart_tx_unit;

    localparam int unsigned FREQ = 500_000;

    logic       Clock;
    logic       Reset;
    logic       Send;
    logic [7:0] DataIn;
    logic [1:0] ParityType;
    logic [1:0] BaudRate;
    logic       DataTx;
    logic       Busy;
    logic       Done;

    int errors = 0;
    int checks = 0;

    uart_tx_unit #(.CLOCK_FREQ(FREQ)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Send      (Send),
        .DataIn    (DataIn),
        .ParityType(ParityType),
        .BaudRate  (BaudRate),
        .DataTx    (DataTx),
        .Busy      (Busy),
        .Done      (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic int n_for(input logic [1:0] b);
        int baud;
        baud = 2400 << b;
        return (int'(FREQ) + baud / 2) / baud;
    endfunction

    // One frame: accept on the first edge, then follow the expected bit list for F cycles.
    // hold keeps Send high so the next call's first edge is the back-to-back acceptance.
    task automatic run_frame(input logic [7:0] d, input logic [1:0] p, input logic [1:0] b,
                             input bit hold, input int disturb_t, input string tag);
        int n, nbits, f, ones;
        logic exp_bits[11];
        logic rec[11];
        logic [7:0] got;
        logic exp_par;
        n = n_for(b);
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = d[i];
        exp_par = (p == 2'b10) ? (ones % 2 == 1) : (ones % 2 == 0);
        if (p == 2'b01 || p == 2'b10) begin
            nbits = 11;
            exp_bits[9] = exp_par;
        end else begin
            nbits = 10;
        end
        exp_bits[nbits-1] = 1'b1;
        f = nbits * n;
        for (int i = 0; i < 11; i++) rec[i] = 1'bx;

        DataIn = d; ParityType = p; BaudRate = b; Send = 1'b1;
        tick();
        Send = hold;
        for (int t = 0; t < f; t++) begin
            if (t > 0) tick();
            if (t == disturb_t) begin
                Send = 1'b1; DataIn = 8'h3C; BaudRate = 2'b00; ParityType = ~p;
            end else if (t == disturb_t + 1) begin
                Send = hold;
            end
            checks++;
            if (DataTx !== exp_bits[t/n]) begin
                errors++;
                $display("FAIL %s line t=%0d bit=%0d: got %b expected %b", tag, t, t/n, DataTx, exp_bits[t/n]);
            end
            checks++;
            if (Busy !== 1'b1 || Done !== 1'b0) begin
                errors++;
                $display("FAIL %s busy/done t=%0d: got %b/%b expected 1/0", tag, t, Busy, Done);
            end
            if (t % n == n / 2) rec[t/n] = DataTx;
        end
        tick();
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0 || DataTx !== 1'b1) begin
            errors++;
            $display("FAIL %s end_of_frame: got done=%b busy=%b tx=%b expected 1 0 1", tag, Done, Busy, DataTx);
        end
        for (int i = 0; i < 8; i++) got[i] = rec[i+1];
        checks++;
        if (got !== d || rec[0] !== 1'b0 || rec[nbits-1] !== 1'b1) begin
            errors++;
            $display("FAIL %s decode: got data=%h start=%b stop=%b expected %h 0 1", tag, got, rec[0], rec[nbits-1], d);
        end
        if (nbits == 11) begin
            checks++;
            if (rec[9] !== exp_par) begin
                errors++;
                $display("FAIL %s parity: got %b expected %b", tag, rec[9], exp_par);
            end
        end
        if (!hold) begin
            tick();
            checks++;
            if (Done !== 1'b0 || Busy !== 1'b0 || DataTx !== 1'b1) begin
                errors++;
                $display("FAIL %s after_done: got done=%b busy=%b tx=%b expected 0 0 1", tag, Done, Busy, DataTx);
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; Send = 1'b1; DataIn = 8'h55; ParityType = 2'b10; BaudRate = 2'b11;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (DataTx !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
                errors++;
                $display("FAIL reset_state cyc=%0d: got tx=%b busy=%b done=%b expected 1 0 0", i, DataTx, Busy, Done);
            end
        end
        Reset = 1'b0; Send = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (DataTx !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d: got tx=%b busy=%b done=%b expected 1 0 0", i, DataTx, Busy, Done);
            end
        end
    endtask

    task automatic test_a5_even();
        run_frame(8'hA5, 2'b10, 2'b11, 1'b0, -1, "a5_19200_even");
    endtask

    task automatic test_ff_parity();
        run_frame(8'hFF, 2'b01, 2'b00, 1'b0, -1, "ff_2400_odd");
        run_frame(8'hFF, 2'b10, 2'b00, 1'b0, -1, "ff_2400_even");
    endtask

    task automatic test_no_parity();
        run_frame(8'h00, 2'b00, 2'b10, 1'b0, -1, "00_9600_p00");
        run_frame(8'h00, 2'b11, 2'b10, 1'b0, -1, "00_9600_p11");
    endtask

    task automatic test_busy_ignore();
        run_frame(8'h5A, 2'b00, 2'b11, 1'b0, 3 * n_for(2'b11) + 5, "busy_ignore");
    endtask

    task automatic test_back_to_back();
        run_frame(8'hC3, 2'b01, 2'b11, 1'b1, -1, "b2b_first");
        run_frame(8'h3C, 2'b10, 2'b10, 1'b0, -1, "b2b_second");
    endtask

    task automatic test_reset_mid_frame();
        int n;
        int bad;
        n = n_for(2'b11);
        DataIn = 8'h96; ParityType = 2'b10; BaudRate = 2'b11; Send = 1'b1;
        tick();
        Send = 1'b0;
        repeat (5 * n + n / 2) tick();
        checks++;
        if (DataTx !== 1'b1 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_bit4: got tx=%b busy=%b expected 1 1", DataTx, Busy);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (DataTx !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_edge: got tx=%b busy=%b done=%b expected 1 0 0", DataTx, Busy, Done);
        end
        bad = 0;
        for (int i = 0; i < 12 * n; i++) begin
            tick();
            if (Done !== 1'b0 || DataTx !== 1'b1 || Busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midreset_quiet: got %0d active cycles expected 0", bad);
        end
        run_frame(8'h96, 2'b10, 2'b11, 1'b0, -1, "after_midreset");
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [1:0] p, b;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            p = 2'($urandom);
            b = 2'($urandom);
            run_frame(d, p, b, 1'b0, -1, $sformatf("random%0d", i));
        end
    endtask

    initial begin
        Reset = 1'b0; Send = 1'b0; DataIn = '0; ParityType = '0; BaudRate = '0;
        test_reset();
        test_a5_even();
        test_ff_parity();
        test_no_parity();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
